// File: rtl/star_seq_ctrl.sv
// Phase sequencer for the STAR softmax datapath: fetches one row at a time,
// strobes CAMSUB / FindSub / EXP in order and accumulates a saturating exp sum per row.
module star_seq_ctrl #(
  parameter int unsigned N_ELEM = 16,
  parameter int unsigned N_ROWS = 16,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned SUM_W  = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        data_req,
  output logic [ADDR_W-1:0]           data_addr,
  input  logic [7:0]                  data,
  output logic [7:0]                  xi,
  output logic                        CAMSUB_req,
  output logic                        FindSub_req,
  output logic                        EXP_req,
  input  logic [7:0]                  exp,
  output logic [SUM_W-1:0]            Sum_exp,
  output logic [$clog2(N_ROWS)-1:0]   row_idx,
  output logic                        row_done,
  output logic                        busy,
  output logic                        finish
);

  localparam int unsigned CNT_W = $clog2(N_ELEM + 1);
  localparam int unsigned ROW_W = $clog2(N_ROWS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_ELEM);
  localparam logic [CNT_W-1:0]  CNT_RUN   = CNT_W'(N_ELEM - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(N_ROWS - 1);
  localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(N_ELEM);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_GAP1, S_FINDSUB, S_GAP2, S_EXP, S_DRAIN, S_ROWEND, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [ROW_W-1:0]    r_row;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_addr_last;
  logic [7:0]          r_xi;
  logic [SUM_W-1:0]    r_acc;
  logic [SUM_W-1:0]    r_sum;

  logic                w_run_init, w_cnt_clr, w_cnt_inc, w_acc_en, w_sum_ld, w_row_adv;
  logic [ADDR_W-1:0]   w_addr;
  logic [SUM_W:0]      w_sum_ext;
  logic [SUM_W-1:0]    w_acc_next;

  assign w_addr     = r_base + ADDR_W'(r_cnt);
  assign w_sum_ext  = {1'b0, r_acc} + (SUM_W + 1)'(exp);
  assign w_acc_next = w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];

  assign data_addr  = data_req ? w_addr : r_addr_last;
  assign xi         = r_xi;
  assign Sum_exp    = r_sum;
  assign row_idx    = r_row;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    data_req    = 1'b0;
    CAMSUB_req  = 1'b0;
    FindSub_req = 1'b0;
    EXP_req     = 1'b0;
    row_done    = 1'b0;
    busy        = 1'b1;
    finish      = 1'b0;
    w_run_init  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_acc_en    = 1'b0;
    w_sum_ld    = 1'b0;
    w_row_adv   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next     = S_FETCH;
          w_run_init = 1'b1;
        end
      end
      S_FETCH: begin
        data_req   = (r_cnt != CNT_LAST);
        CAMSUB_req = (r_cnt != '0);
        if (r_cnt == CNT_LAST) begin
          w_next    = S_GAP1;
          w_cnt_clr = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_GAP1: w_next = S_FINDSUB;
      S_FINDSUB: begin
        FindSub_req = 1'b1;
        if (r_cnt == CNT_RUN) begin
          w_next    = S_GAP2;
          w_cnt_clr = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_GAP2: w_next = S_EXP;
      S_EXP: begin
        EXP_req  = 1'b1;
        w_acc_en = (r_cnt != '0);
        if (r_cnt == CNT_RUN) begin
          w_next    = S_DRAIN;
          w_cnt_clr = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      // Final sample lands here; Sum_exp is loaded now so it is valid during row_done.
      S_DRAIN: begin
        w_acc_en = 1'b1;
        w_sum_ld = 1'b1;
        w_next   = S_ROWEND;
      end
      S_ROWEND: begin
        row_done = 1'b1;
        if (r_row == ROW_LAST) begin
          w_next = S_DONE;
        end else begin
          w_next    = S_FETCH;
          w_row_adv = 1'b1;
        end
      end
      S_DONE: begin
        busy   = 1'b0;
        finish = 1'b1;
        if (start) begin
          w_next     = S_FETCH;
          w_run_init = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_row       <= '0;
      r_base      <= '0;
      r_addr_last <= '0;
      r_xi        <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
    end else begin
      if (w_run_init || w_cnt_clr) r_cnt <= '0;
      else if (w_cnt_inc)          r_cnt <= r_cnt + 1'b1;

      if (w_run_init) begin
        r_row  <= '0;
        r_base <= '0;
      end else if (w_row_adv) begin
        r_row  <= r_row + 1'b1;
        r_base <= r_base + BASE_STEP;
      end

      if (w_run_init || w_row_adv) r_acc <= '0;
      else if (w_acc_en)           r_acc <= w_acc_next;

      if (w_sum_ld) r_sum <= w_acc_next;

      if (data_req) begin
        r_addr_last <= w_addr;
        r_xi        <= data;
      end
    end
  end

endmodule
